// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command frame parser.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_CMD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd, input logic [7:0] addr,
                                            input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and register-strobe outputs of the command parser, grouped as one bundle.
interface uart_cmd_ctrl_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Wr_En;
  logic [7:0] o_Wr_Addr;
  logic [7:0] o_Wr_Data;
  logic       o_Rd_En;
  logic [7:0] o_Rd_Addr;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;
  logic       o_Busy;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Rd_En, o_Rd_Addr, o_Frame_Err, o_Err_Code, o_Busy
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Rd_En, o_Rd_Addr, o_Frame_Err, o_Err_Code, o_Busy
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Saturating inter-byte gap counter; o_expire flags the last permitted idle clock.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CLKS = 34720
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clr,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CLKS);
  localparam logic [CW-1:0] CNT_EXP = CW'(TIMEOUT_CLKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == CNT_EXP);
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte SOF/CMD/ADDR/DATA/CSUM frames and issues one-cycle register strobes.
//  state  | meaning
//  S_IDLE | hunting for SOF 0xA5, other bytes ignored
//  S_CMD  | waiting for command byte
//  S_ADDR | waiting for address byte
//  S_DATA | waiting for data byte
//  S_CSUM | waiting for checksum; frame verdict issued on acceptance
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 34720
) (
  input logic            i_Clock,
  input logic            i_Reset,
  uart_cmd_ctrl_if.slave bus
);
  state_t     state, state_nxt;
  logic [7:0] cmd_q, addr_q, data_q, cmd_d, addr_d, data_d;
  logic       wr_en_q, rd_en_q, err_q, wr_en_d, rd_en_d, err_d;
  logic [7:0] wr_addr_q, wr_data_q, rd_addr_q, wr_addr_d, wr_data_d, rd_addr_d;
  logic [1:0] err_code_q, err_code_d;
  logic       rx_dv, tmo_clr, tmo_expire;
  logic [7:0] rx_byte;

  assign rx_dv   = bus.i_Rx_DV;
  assign rx_byte = bus.i_Rx_Byte;
  assign tmo_clr = (state == S_IDLE) || rx_dv;

  uart_cmd_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .clr     (tmo_clr),
    .expire  (tmo_expire)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      err_code_q <= '0;
    end else begin
      state      <= state_nxt;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    err_code_d = err_code_q;
    case (state)
      S_IDLE: if (rx_dv && rx_byte == SOF_BYTE) state_nxt = S_CMD;
      S_CMD:  if (rx_dv) begin cmd_d  = rx_byte; state_nxt = S_ADDR; end
      S_ADDR: if (rx_dv) begin addr_d = rx_byte; state_nxt = S_DATA; end
      S_DATA: if (rx_dv) begin data_d = rx_byte; state_nxt = S_CSUM; end
      S_CSUM: if (rx_dv) begin
        state_nxt = S_IDLE;
        if (rx_byte != frame_csum(cmd_q, addr_q, data_q)) begin
          err_d      = 1'b1;
          err_code_d = ERR_CSUM;
        end else if (cmd_q == CMD_WR) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = data_q;
        end else if (cmd_q == CMD_RD) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
        end else begin
          err_d      = 1'b1;
          err_code_d = ERR_CMD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A byte on the expiry cycle is accepted above, so expiry only acts without rx_dv.
    if (state inside {S_CMD, S_ADDR, S_DATA, S_CSUM} && !rx_dv && tmo_expire) begin
      state_nxt  = S_IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  assign bus.o_Wr_En     = wr_en_q;
  assign bus.o_Wr_Addr   = wr_addr_q;
  assign bus.o_Wr_Data   = wr_data_q;
  assign bus.o_Rd_En     = rd_en_q;
  assign bus.o_Rd_Addr   = rd_addr_q;
  assign bus.o_Frame_Err = err_q;
  assign bus.o_Err_Code  = err_code_q;
  assign bus.o_Busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frames driven at negedge, outputs checked at negedge.
module tb_uart_cmd_ctrl;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.TIMEOUT_CLKS(TMO)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strobes {wr, rd, err} as one 3-bit value
  task automatic chk_strb(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.o_Wr_En, bus.o_Rd_En, bus.o_Frame_Err}, {29'd0, exp});
  endtask

  task automatic put(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.i_Rx_DV = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic put_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] s);
    put(8'hA5); put(c); put(a); put(d); put(s);
  endtask

  initial begin
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk_strb("reset_strobes", 3'b000);
    chk("reset_busy", {31'd0, bus.o_Busy}, 32'd0);
    chk("reset_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'h00);
    chk("reset_err_code", {30'd0, bus.o_Err_Code}, 32'd0);

    // 1: write frame
    put(8'hA5);
    chk("busy_after_sof", {31'd0, bus.o_Busy}, 32'd1);
    put(8'h57); put(8'h10); put(8'h3C); put(8'h7B);
    chk_strb("t1_wr_strobe", 3'b100);
    chk("t1_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'h10);
    chk("t1_wr_data", {24'd0, bus.o_Wr_Data}, 32'h3C);
    chk("t1_busy", {31'd0, bus.o_Busy}, 32'd0);
    idle(1);
    chk_strb("t1_one_cycle", 3'b000);
    chk("t1_addr_held", {24'd0, bus.o_Wr_Addr}, 32'h10);

    // 2: read frame
    put_frame(8'h52, 8'h22, 8'h00, 8'h70);
    chk_strb("t2_rd_strobe", 3'b010);
    chk("t2_rd_addr", {24'd0, bus.o_Rd_Addr}, 32'h22);
    chk("t2_wr_addr_kept", {24'd0, bus.o_Wr_Addr}, 32'h10);
    chk("t2_wr_data_kept", {24'd0, bus.o_Wr_Data}, 32'h3C);
    idle(1);
    chk_strb("t2_one_cycle", 3'b000);

    // 3: bad checksum, then illegal command
    put_frame(8'h57, 8'h10, 8'h3C, 8'h00);
    chk_strb("t3_csum_strobe", 3'b001);
    chk("t3_csum_code", {30'd0, bus.o_Err_Code}, 32'd1);
    idle(1);
    chk_strb("t3_one_cycle", 3'b000);
    chk("t3_code_held", {30'd0, bus.o_Err_Code}, 32'd1);
    put_frame(8'h41, 8'h01, 8'h02, 8'h42);
    chk_strb("t3_cmd_strobe", 3'b001);
    chk("t3_cmd_code", {30'd0, bus.o_Err_Code}, 32'd2);
    idle(1);

    // 4: garbage ignored, truncated frame swallows following bytes, back-to-back frames
    put(8'h00); put(8'hFF); put(8'h3C);
    chk("t4_garbage_busy", {31'd0, bus.o_Busy}, 32'd0);
    chk_strb("t4_garbage_quiet", 3'b000);
    put_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    chk_strb("t4_wr_after_garbage", 3'b100);
    idle(1);
    chk_strb("t4_single_strobe", 3'b000);
    // A5 57 A5 57 10 -> CMD=57 ADDR=A5 DATA=57, csum A5 != 10
    put(8'hA5); put(8'h57);
    put_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    chk_strb("t4_trunc_none_yet", 3'b000);
    chk("t4_trunc_busy", {31'd0, bus.o_Busy}, 32'd0);
    idle(1);
    put(8'hA5); put(8'h57); put(8'hA5); put(8'h57); put(8'h10);
    chk_strb("t4_a5_as_data", 3'b001);
    chk("t4_a5_code", {30'd0, bus.o_Err_Code}, 32'd1);
    put_frame(8'h57, 8'h11, 8'h22, 8'h64);
    chk_strb("t4_b2b_wr", 3'b100);
    chk("t4_b2b_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'h11);
    put_frame(8'h52, 8'h33, 8'h44, 8'h25);
    chk_strb("t4_b2b_rd", 3'b010);
    chk("t4_b2b_rd_addr", {24'd0, bus.o_Rd_Addr}, 32'h33);
    idle(1);

    // 5: timeout after A5 57
    put(8'hA5); put(8'h57);
    idle(TMO - 1);
    chk_strb("t5_before_expiry", 3'b000);
    chk("t5_busy_before", {31'd0, bus.o_Busy}, 32'd1);
    idle(1);
    chk_strb("t5_timeout_strobe", 3'b001);
    chk("t5_timeout_code", {30'd0, bus.o_Err_Code}, 32'd3);
    chk("t5_busy_falls", {31'd0, bus.o_Busy}, 32'd0);
    idle(1);
    chk_strb("t5_one_cycle", 3'b000);
    put_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    chk_strb("t5_wr_after_tmo", 3'b100);
    idle(1);
    // byte lands exactly on the expiry cycle
    put(8'hA5); put(8'h57);
    idle(TMO - 1);
    put(8'h10);
    chk_strb("t5_edge_no_tmo", 3'b000);
    chk("t5_edge_busy", {31'd0, bus.o_Busy}, 32'd1);
    put(8'h3C); put(8'h7B);
    chk_strb("t5_edge_wr", 3'b100);
    idle(1);

    // 6: reset mid-frame
    put(8'hA5); put(8'h57); put(8'h10);
    bus.i_Rx_DV = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_strb("t6_rst_strobes", 3'b000);
    chk("t6_rst_busy", {31'd0, bus.o_Busy}, 32'd0);
    chk("t6_rst_wr_addr", {24'd0, bus.o_Wr_Addr}, 32'h00);
    chk("t6_rst_wr_data", {24'd0, bus.o_Wr_Data}, 32'h00);
    chk("t6_rst_rd_addr", {24'd0, bus.o_Rd_Addr}, 32'h00);
    chk("t6_rst_code", {30'd0, bus.o_Err_Code}, 32'd0);
    put(8'h3C); put(8'h7B);
    chk_strb("t6_tail_ignored", 3'b000);
    chk("t6_tail_busy", {31'd0, bus.o_Busy}, 32'd0);
    idle(1);
    put_frame(8'h57, 8'h10, 8'h3C, 8'h7B);
    chk_strb("t6_wr_after_rst", 3'b100);
    chk("t6_wr_data", {24'd0, bus.o_Wr_Data}, 32'h3C);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
